// File: rtl/psum_drain_ctrl.sv
// Drains per-column psum FIFOs round-robin into the ofmap BRAM.
// Ports: clk_i/rst_ni, start_i, psum_empty_i/psum_i in, psum_rd_en_o pop,
// ofmap_wr_* registered write, busy_o (RUN), done_o (one-cycle pulse).
// Optional macro PSUM_DRAIN_RELU_EN: negative words are written as zero.
module psum_drain_ctrl #(
  parameter int G_ARRAY_WIDTH      = 6,
  parameter int G_DATA_WIDTH       = 16,
  parameter int G_OUT_HEIGHT       = 24,
  parameter int G_OUT_WIDTH        = 24,
  parameter int G_ROW_STRIDE       = 6,
  parameter int G_OFMAP_ADDR_WIDTH = 10
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         start_i,
  input  logic [0:G_ARRAY_WIDTH-1]     psum_empty_i,
  input  logic [0:G_ARRAY_WIDTH-1][G_DATA_WIDTH-1:0] psum_i,
  output logic [0:G_ARRAY_WIDTH-1]     psum_rd_en_o,
  output logic                         ofmap_wr_en_o,
  output logic [G_OFMAP_ADDR_WIDTH-1:0] ofmap_wr_addr_o,
  output logic [G_DATA_WIDTH-1:0]      ofmap_data_o,
  output logic                         busy_o,
  output logic                         done_o
);

  localparam int NUM_PASSES =
    (G_OUT_HEIGHT + G_ROW_STRIDE - 1) / G_ROW_STRIDE;
  localparam int KW = (G_OUT_WIDTH > 1) ? $clog2(G_OUT_WIDTH) : 1;
  localparam int NW = $clog2(NUM_PASSES + 1);
  localparam int PW = (G_ARRAY_WIDTH > 1) ? $clog2(G_ARRAY_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  state_e state_q, state_d;
  logic [KW-1:0] k_q [G_ARRAY_WIDTH];
  logic [KW-1:0] k_d [G_ARRAY_WIDTH];
  logic [NW-1:0] n_q [G_ARRAY_WIDTH];
  logic [NW-1:0] n_d [G_ARRAY_WIDTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [0:G_ARRAY_WIDTH-1] last_q, last_d;
  logic [0:G_ARRAY_WIDTH-1] elig;
  logic [0:G_ARRAY_WIDTH-1] grant;
  logic wr_en_q, wr_en_d;
  logic [G_OFMAP_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [G_DATA_WIDTH-1:0] data_q, data_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic found;
  logic all_done;
  int   gidx;
  int   idx;
  int   row;
  int   lin;

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    n_d      = n_q;
    ptr_d    = ptr_q;
    last_d   = '0;
    grant    = '0;
    wr_en_d  = 1'b0;
    addr_d   = addr_q;
    data_d   = data_q;
    found    = 1'b0;
    all_done = 1'b1;
    gidx     = 0;
    idx      = 0;
    row      = 0;
    lin      = 0;

    // A column popped last cycle is skipped so its FWFT head can refresh.
    for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
      elig[c] = (state_q == S_RUN) && !psum_empty_i[c] &&
                !last_q[c] && (n_q[c] != NW'(NUM_PASSES));
    end

    for (int i = 0; i < G_ARRAY_WIDTH; i++) begin
      idx = (int'(ptr_q) + i) % G_ARRAY_WIDTH;
      if (!found && elig[idx]) begin
        found = 1'b1;
        gidx  = idx;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_RUN;
          ptr_d   = '0;
          for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
            k_d[c] = '0;
            n_d[c] = '0;
          end
        end
      end
      S_RUN: begin
        if (found) begin
          grant[gidx] = 1'b1;
          last_d      = grant;
          ptr_d = (gidx == G_ARRAY_WIDTH - 1) ? '0 : PW'(gidx + 1);
          row = gidx + int'(n_q[gidx]) * G_ROW_STRIDE;
          lin = row * G_OUT_WIDTH + int'(k_q[gidx]);
          // Rows past the ofmap bottom are popped to drain but discarded.
          if (row < G_OUT_HEIGHT) begin
            wr_en_d = 1'b1;
            addr_d  = G_OFMAP_ADDR_WIDTH'(lin);
`ifdef PSUM_DRAIN_RELU_EN
            data_d  = psum_i[gidx][G_DATA_WIDTH-1] ? '0 : psum_i[gidx];
`else
            data_d  = psum_i[gidx];
`endif
          end
          if (k_q[gidx] == KW'(G_OUT_WIDTH - 1)) begin
            k_d[gidx] = '0;
            n_d[gidx] = n_q[gidx] + NW'(1);
          end else begin
            k_d[gidx] = k_q[gidx] + KW'(1);
          end
        end
        for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
          if (n_d[c] != NW'(NUM_PASSES)) all_done = 1'b0;
        end
        if (all_done) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      last_q  <= '0;
      wr_en_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
        k_q[c] <= '0;
        n_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      wr_en_q <= wr_en_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int c = 0; c < G_ARRAY_WIDTH; c++) begin
        k_q[c] <= k_d[c];
        n_q[c] <= n_d[c];
      end
    end
  end

  assign psum_rd_en_o    = grant;
  assign ofmap_wr_en_o   = wr_en_q;
  assign ofmap_wr_addr_o = addr_q;
  assign ofmap_data_o    = data_q;
  assign busy_o          = busy_q;
  assign done_o          = done_q;

endmodule
